// File: rtl/tdc_bus_responder_pkg.sv
// Shared constants, bus-cycle state type and status-word packing for the TDC bus responder.
// Imported by the interface, the hit FIFO and the top level.
package tdc_bus_responder_pkg;

    localparam int DATA_W     = 28;
    localparam int FIFO_DEPTH = 8;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;
    localparam int ADDR_W     = 4;

    localparam logic [ADDR_W-1:0] ADDR_CFG0   = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_CFG3   = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_FIFO1  = 4'd8;
    localparam logic [ADDR_W-1:0] ADDR_FIFO2  = 4'd9;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'd10;

    localparam int STAT_CNT1_LSB = 0;
    localparam int STAT_CNT2_LSB = 4;
    localparam int STAT_OVF1_BIT = 8;
    localparam int STAT_OVF2_BIT = 9;

    // BUS_LOCK is the post-reset state: strobes must be seen idle before any access starts.
    typedef enum logic [2:0] {
        BUS_IDLE  = 3'd0,
        BUS_READ  = 3'd1,
        BUS_WRITE = 3'd2,
        BUS_BOTH  = 3'd3,
        BUS_LOCK  = 3'd4
    } bus_state_e;

    function automatic bus_state_e decode_bus(input logic csn, input logic rdn, input logic wrn);
        bus_state_e op;
        op = BUS_IDLE;
        if (!csn) begin
            case ({rdn, wrn})
                2'b01:   op = BUS_READ;
                2'b10:   op = BUS_WRITE;
                2'b00:   op = BUS_BOTH;
                default: op = BUS_IDLE;
            endcase
        end
        return op;
    endfunction

    function automatic logic [DATA_W-1:0] status_word(input logic [CNT_W-1:0] cnt1,
                                                      input logic [CNT_W-1:0] cnt2,
                                                      input logic ovf1, input logic ovf2);
        logic [DATA_W-1:0] w;
        w = '0;
        w[STAT_CNT1_LSB +: CNT_W] = cnt1;
        w[STAT_CNT2_LSB +: CNT_W] = cnt2;
        w[STAT_OVF1_BIT]          = ovf1;
        w[STAT_OVF2_BIT]          = ovf2;
        return w;
    endfunction

endpackage

// File: rtl/tdc_bus_responder_if.sv
// Host bus control signals; the responder publishes its bus-cycle state for observation.
interface tdc_bus_responder_if;
    import tdc_bus_responder_pkg::*;

    // A read or write starts on the first clk edge that samples its strobe pattern after
    // an edge that sampled anything else; strobes low together are ignored.
    logic              csn_in;
    logic              rdn_in;
    logic              wrn_in;
    logic [ADDR_W-1:0] addr_in;
    bus_state_e        bus_state;

    modport master (output csn_in, rdn_in, wrn_in, addr_in, input bus_state);
    modport slave  (input csn_in, rdn_in, wrn_in, addr_in, output bus_state);

endinterface

// File: rtl/tdc_hit_fifo.sv
// 8-deep hit timestamp FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module tdc_hit_fifo
    import tdc_bus_responder_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // 3-bit pointers wrap naturally at depth 8.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/tdc_bus_responder.sv
// Bus-mapped TDC hit readout: four config registers, two hit FIFOs and a clear-on-read status word.
module tdc_bus_responder
    import tdc_bus_responder_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    tdc_bus_responder_if.slave  bus,
    inout  wire  [DATA_W-1:0]   data_io,
    input  logic                hit1_valid_in,
    input  logic                hit2_valid_in,
    input  logic [DATA_W-1:0]   hit1_data_in,
    input  logic [DATA_W-1:0]   hit2_data_in,
    output logic                EF1_out,
    output logic                EF2_out,
    output logic [DATA_W-1:0]   cfg0_out,
    output logic [DATA_W-1:0]   cfg1_out,
    output logic [DATA_W-1:0]   cfg2_out,
    output logic [DATA_W-1:0]   cfg3_out
);

    bus_state_e        op_now;
    bus_state_e        state_q;
    bus_state_e        state_n;
    logic              rd_start;
    logic              wr_start;
    logic              drive_q;
    logic [DATA_W-1:0] rd_reg;
    logic [DATA_W-1:0] rd_sel;
    logic [DATA_W-1:0] cfg_q [4];
    logic              ovf1_q, ovf2_q;
    logic              ovf1_set, ovf2_set;
    logic              status_clr;
    logic              pop1, pop2;
    logic [DATA_W-1:0] head1, head2;
    logic [CNT_W-1:0]  cnt1, cnt2;
    logic              full1, full2;
    logic              empty1, empty2;

    // state_q remembers what the previous edge sampled, so a held strobe yields one start.
    always_comb begin
        op_now   = decode_bus(bus.csn_in, bus.rdn_in, bus.wrn_in);
        state_n  = op_now;
        if (state_q == BUS_LOCK && op_now != BUS_IDLE) state_n = BUS_LOCK;
        rd_start = (op_now == BUS_READ)  && (state_q != BUS_READ)  && (state_q != BUS_LOCK);
        wr_start = (op_now == BUS_WRITE) && (state_q != BUS_WRITE) && (state_q != BUS_LOCK);
    end

    assign pop1       = rd_start && (bus.addr_in == ADDR_FIFO1);
    assign pop2       = rd_start && (bus.addr_in == ADDR_FIFO2);
    assign status_clr = rd_start && (bus.addr_in == ADDR_STATUS);
    // A pop on a full FIFO makes room, so only an unpaired push to a full FIFO overflows.
    assign ovf1_set   = hit1_valid_in & full1 & ~pop1;
    assign ovf2_set   = hit2_valid_in & full2 & ~pop2;

    always_comb begin
        rd_sel = '0;
        if (bus.addr_in[3:2] == 2'b00) begin
            rd_sel = cfg_q[bus.addr_in[1:0]];
        end else begin
            case (bus.addr_in)
                ADDR_FIFO1:  if (!empty1) rd_sel = head1;
                ADDR_FIFO2:  if (!empty2) rd_sel = head2;
                ADDR_STATUS: rd_sel = status_word(cnt1, cnt2, ovf1_q, ovf2_q);
                default:     rd_sel = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= BUS_LOCK;
            drive_q <= 1'b0;
            rd_reg  <= '0;
            ovf1_q  <= 1'b0;
            ovf2_q  <= 1'b0;
            EF1_out <= 1'b0;
            EF2_out <= 1'b0;
            for (int i = 0; i < 4; i++) cfg_q[i] <= '0;
        end else begin
            state_q <= state_n;
            drive_q <= (op_now == BUS_READ);
            if (rd_start) rd_reg <= rd_sel;
            ovf1_q  <= (ovf1_q & ~status_clr) | ovf1_set;
            ovf2_q  <= (ovf2_q & ~status_clr) | ovf2_set;
            EF1_out <= ~empty1;
            EF2_out <= ~empty2;
            if (wr_start && bus.addr_in[3:2] == 2'b00) cfg_q[bus.addr_in[1:0]] <= data_io;
        end
    end

    // resetn gating keeps the bus released for the whole reset, not only after the first edge.
    assign data_io       = (drive_q && resetn) ? rd_reg : {DATA_W{1'bz}};
    assign bus.bus_state = state_q;
    assign cfg0_out      = cfg_q[0];
    assign cfg1_out      = cfg_q[1];
    assign cfg2_out      = cfg_q[2];
    assign cfg3_out      = cfg_q[3];

    tdc_hit_fifo u_fifo1 (
        .clk       (clk),
        .resetn    (resetn),
        .push      (hit1_valid_in),
        .push_data (hit1_data_in),
        .pop       (pop1),
        .head      (head1),
        .count     (cnt1),
        .full      (full1),
        .empty     (empty1)
    );

    tdc_hit_fifo u_fifo2 (
        .clk       (clk),
        .resetn    (resetn),
        .push      (hit2_valid_in),
        .push_data (hit2_data_in),
        .pop       (pop2),
        .head      (head2),
        .count     (cnt2),
        .full      (full2),
        .empty     (empty2)
    );

endmodule

// File: doc/tdc_bus_responder.md
TDC_BUS_RESPONDER -- requirements
Module: tdc_bus_responder
Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-002 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-003 SHALL have port csn_in, input, 1, bus chip select, active low.
REQ-004 SHALL have port rdn_in, input, 1, bus read strobe, active low.
REQ-005 SHALL have port wrn_in, input, 1, bus write strobe, active low.
REQ-006 SHALL have port addr_in, input, 4, bus register address.
REQ-007 SHALL have port data_io, inout, 28, bidirectional bus data.
REQ-008 SHALL have ports hit1_valid_in and hit2_valid_in, each input, 1, push strobes for FIFO1 and FIFO2.
REQ-009 SHALL have ports hit1_data_in and hit2_data_in, each input, 28, timestamps pushed into FIFO1 and FIFO2.
REQ-010 SHALL have ports EF1_out and EF2_out, each output, 1, high = corresponding FIFO holds at least 1 entry.
REQ-011 SHALL have ports cfg0_out..cfg3_out, each output, 28, configuration register contents.
Function
REQ-012 Address map SHALL be: 0-3 cfg R/W; 4-7 reserved (write ignored, read 0); 8 FIFO1 pop; 9 FIFO2 pop; 10 status, read-only, clear-on-read; 11-15 read 0.
REQ-013 Status word SHALL be: [3:0] FIFO1 count, [7:4] FIFO2 count, [8] ovf1, [9] ovf2, [27:10] zero.
REQ-014 FIFO1 and FIFO2 SHALL each be 8 deep x 28 bits, first-in first-out; count range 0..8.
REQ-015 Read start SHALL be the first clk edge sampling csn_in=0, rdn_in=0, wrn_in=1 after an edge sampling otherwise.
REQ-016 At read start, the module SHALL latch the selected word into the read register and, for addr 8/9 with a non-empty FIFO, pop 1 entry.
REQ-017 A read of an empty FIFO SHALL return 0 and SHALL NOT pop.
REQ-018 data_io SHALL be driven with the read register whenever the module's own registered copy of (!csn & !rdn & wrn) is true, otherwise high-Z; read latency 1 cycle, data valid from the cycle after read start until release.
REQ-019 Write commit SHALL occur on the first clk edge sampling csn_in=0, wrn_in=0, rdn_in=1, capturing addr_in and data_io; exactly 1 commit per strobe.
REQ-020 A write commit SHALL update only cfg0-cfg3; writes to all other addresses SHALL be ignored.
REQ-021 csn_in=0 with rdn_in=0 and wrn_in=0 together SHALL be ignored: no pop, no write, bus not driven.
REQ-022 A push with valid=1 SHALL append the data; a push to a full FIFO without a simultaneous pop SHALL drop the data and set the sticky ovfN bit.
REQ-023 A push and pop on the same FIFO in the same cycle SHALL both take effect, leaving count unchanged; this SHALL also apply when the FIFO is full.
REQ-024 A status read SHALL return the pre-clear flags and clear ovf1/ovf2 at read start; an overflow in that same cycle SHALL win, leaving the flag set.
REQ-025 EF1_out and EF2_out SHALL be registered, reflecting count != 0 one cycle after the count changes.
REQ-026 FIFO read/write pointers SHALL wrap modulo 8.
Reset
REQ-027 While resetn=0: FIFOs emptied, ovf flags 0, EF1_out=EF2_out=0, cfg0_out-cfg3_out=0, read register 0, data_io high-Z.
REQ-028 Reset asserted mid-access SHALL abort the access; a strobe still held low after reset release SHALL NOT be treated as a new read start or write commit until it is first seen high.
Structure
REQ-029 A shared package SHALL hold: address map constants, FIFO depth 8, data width 28, count width 4, status bit positions.
REQ-030 FIFO logic SHALL be one sub-module, tdc_hit_fifo, instantiated twice; it SHALL provide push, pop, head data, count, full and empty.
REQ-031 Bus decode, the read register, cfg registers and ovf flags SHALL live in the top module.
Verification
REQ-032 Write cfg2=0x0ABCDEF via a 4-cycle write strobe -> cfg2_out=0x0ABCDEF; reading addr 2 returns 0x0ABCDEF; cfg0, cfg1 and cfg3 stay 0.
REQ-033 Push 0x0000011 then 0x0000022 into FIFO1 -> EF1_out=1; read addr 8 twice -> 0x0000011, then 0x0000022; EF1_out=0 after the second pop; a third read returns 0.
REQ-034 Push 9 entries into FIFO2 -> count 8, status read returns 0x0000280 (count2=8, ovf2=1); an immediate second status read returns 0x0000080.
REQ-035 With FIFO1 full, push 0x1234567 in the same cycle as an addr 8 pop -> count stays 8, ovf1 stays 0, and 0x1234567 is returned by the 8th subsequent pop.
REQ-036 Drive csn=0, rdn=0, wrn=0 with addr 8 and FIFO1 non-empty -> data_io high-Z, count unchanged, no cfg change.
REQ-037 Assert resetn=0 mid-read of addr 9 while rdn is held low -> all outputs at reset values; after release, no pop until rdn is seen high then low again.
